// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding and default width.
package serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full adder from two half adders; the only arithmetic in the serial adder.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
    half_adder u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of full_adder_bit.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: sequences one full-adder cell LSB first over WIDTH cycles,
// publishing {cout,sum} only on the completion edge.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic fa_s;
    logic fa_co;

    full_adder_bit u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .cin(carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    acc_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                // Sum bits enter at the MSB so after WIDTH shifts bit 0 lands at the LSB.
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                acc_d   = {fa_s, acc_q[WIDTH-1:1]};
                carry_d = fa_co;
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                    sum_d   = acc_d;
                    cout_d  = fa_co;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl against an a+b reference with timing expectations.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int checks = 0;
    int errors = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Launches one operation and observes busy/done over a bounded window.
    // Sample j is taken on the falling edge after accept edge k+j.
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         output int done_at, output int done_cnt, output int busy_cnt);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        done_at = -1; done_cnt = 0; busy_cnt = 0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = j;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, cout, sum} !== '0) begin errors++;
            $display("FAIL reset_in: busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if ({busy, done, cout, sum} !== '0) begin errors++;
            $display("FAIL reset_out: busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum); end
    endtask

    task automatic test_basic(input logic [W-1:0] ta, input logic [W-1:0] tb, input string name);
        int dat, dcnt, bcnt;
        logic [W:0] exp;
        exp = ref_add(ta, tb);
        do_op(ta, tb, dat, dcnt, bcnt);
        checks++; if ({cout, sum} !== exp) begin errors++;
            $display("FAIL %s_result: got %b_%h want %b_%h", name, cout, sum, exp[W], exp[W-1:0]); end
        checks++; if (dat != W) begin errors++;
            $display("FAIL %s_done_time: got %0d want %0d", name, dat, W); end
        checks++; if (dcnt != 1) begin errors++;
            $display("FAIL %s_done_count: got %0d want 1", name, dcnt); end
        checks++; if (bcnt != W + 1) begin errors++;
            $display("FAIL %s_busy_cycles: got %0d want %0d", name, bcnt, W + 1); end
    endtask

    task automatic test_hold;
        int dat, dcnt, bcnt;
        bit held_ok;
        do_op(8'hA5, 8'h5A, dat, dcnt, bcnt);
        checks++; if ({cout, sum} !== 9'h0FF) begin errors++;
            $display("FAIL hold_first: got %b_%h want 0_ff", cout, sum); end
        @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        held_ok = 1'b1;
        for (int j = 0; j < W; j++) begin
            @(negedge clk);
            if ({cout, sum} !== 9'h0FF || done) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++;
            $display("FAIL hold_partial: sum/cout moved before done (now %b_%h want 0_ff)", cout, sum); end
        @(negedge clk);
        checks++; if (!done || {cout, sum} !== 9'h1FE) begin errors++;
            $display("FAIL hold_second: done=%b got %b_%h want done=1 1_fe", done, cout, sum); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ignore_start;
        logic [W-1:0] ta, tb;
        logic [W:0] exp;
        int dcnt, bcnt;
        ta = W'($urandom); tb = W'($urandom);
        exp = ref_add(ta, tb);
        @(negedge clk);
        a = ta; b = tb; start = 1'b1;
        @(posedge clk);
        dcnt = 0; bcnt = 0;
        for (int j = 0; j < W + 5; j++) begin
            #1;
            if (start) begin a = W'($urandom); b = W'($urandom); end
            @(negedge clk);
            if (busy) bcnt++;
            if (done) dcnt++;
            // Keep start high through the DONE edge, drop it before IDLE could accept.
            if (j == W + 1) start = 1'b0;
        end
        checks++; if ({cout, sum} !== exp) begin errors++;
            $display("FAIL ignore_result: got %b_%h want %b_%h", cout, sum, exp[W], exp[W-1:0]); end
        checks++; if (dcnt != 1) begin errors++;
            $display("FAIL ignore_done_count: got %0d want 1", dcnt); end
        checks++; if (bcnt != W + 1) begin errors++;
            $display("FAIL ignore_busy_cycles: got %0d want %0d", bcnt, W + 1); end
    endtask

    task automatic test_reset_mid_run;
        int dat, dcnt, bcnt;
        bit saw_done;
        @(negedge clk);
        a = 8'h7F; b = 8'h01; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, cout, sum} !== '0) begin errors++;
            $display("FAIL midrst_clear: busy=%b done=%b cout=%b sum=%h want all 0", busy, done, cout, sum); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int j = 0; j < W + 4; j++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        checks++; if (saw_done || {cout, sum} !== '0) begin errors++;
            $display("FAIL midrst_quiet: activity=%b got %b_%h want 0 0_00", saw_done, cout, sum); end
        do_op(8'h10, 8'h20, dat, dcnt, bcnt);
        checks++; if ({cout, sum} !== 9'h030 || dcnt != 1) begin errors++;
            $display("FAIL midrst_next: got %b_%h dones=%0d want 0_30 dones=1", cout, sum, dcnt); end
    endtask

    task automatic test_random(input int n);
        int dat, dcnt, bcnt;
        logic [W-1:0] ta, tb;
        logic [W:0] exp;
        for (int i = 0; i < n; i++) begin
            ta = W'($urandom); tb = W'($urandom);
            exp = ref_add(ta, tb);
            do_op(ta, tb, dat, dcnt, bcnt);
            checks++; if ({cout, sum} !== exp || dat != W || dcnt != 1) begin errors++;
                $display("FAIL random_%0d: %h+%h got %b_%h at %0d (x%0d) want %b_%h at %0d",
                         i, ta, tb, cout, sum, dat, dcnt, exp[W], exp[W-1:0], W); end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        logic [W:0] expq[$];
        logic [W:0] exp;
        int last_done, ndone;
        @(negedge clk);
        a = W'($urandom); b = W'($urandom); start = 1'b1;
        expq.push_back(ref_add(a, b));
        @(posedge clk);
        last_done = W - (W + 2);
        ndone = 0;
        for (int j = 0; j < 3 * (W + 2); j++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                exp = (expq.size() > 0) ? expq.pop_front() : '1;
                checks++; if ({cout, sum} !== exp) begin errors++;
                    $display("FAIL b2b_result_%0d: got %b_%h want %b_%h", ndone, cout, sum, exp[W], exp[W-1:0]); end
                checks++; if (j != last_done + W + 2) begin errors++;
                    $display("FAIL b2b_spacing_%0d: done at %0d want %0d", ndone, j, last_done + W + 2); end
                last_done = j;
                a = W'($urandom); b = W'($urandom);
                if (j + 2 < 3 * (W + 2)) expq.push_back(ref_add(a, b));
            end
            if (j == 3 * (W + 2) - 1) start = 1'b0;
        end
        checks++; if (ndone != 3 || expq.size() != 0) begin errors++;
            $display("FAIL b2b_count: dones=%0d pending=%0d want 3 and 0", ndone, expq.size()); end
        repeat (W + 3) @(negedge clk);
        checks++; if (busy || done) begin errors++;
            $display("FAIL b2b_idle: busy=%b done=%b want 0 0", busy, done); end
    endtask

    initial begin
        test_reset();
        test_basic(8'h00, 8'h00, "zero");
        test_basic(8'hFF, 8'h01, "ripple");
        test_hold();
        test_ignore_start();
        test_reset_mid_run();
        test_random(12);
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule
